md_unit: RTL

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It owns the HI and LO registers and executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo. Its `HI_LO_rdata` result travels down the pipeline into the M/W pipeline registers as the HI/LO value written back. The unit keeps `busy` high for a fixed multi-cycle latency, and it raises `stall_req` so the hazard logic can freeze F/D while any HI/LO-using instruction would conflict with an operation in flight.

---
 rtl/md_unit_pkg.sv | 27 ++
 rtl/md_arith.sv | 50 +++++
 rtl/md_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// md_unit shared definitions: HI/LO op encodings, FSM states, op helpers.
package md_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || is_div_op(op);
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational mult/div datapath on the latched operands.
// Produces next HI/LO and a divide-by-zero flag.
module md_arith
  import md_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        ovf;
  logic [31:0] bs;
  logic [31:0] bu;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  // low 64 bits of sign-extended product equal the signed product
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign div_by_zero = (b == 32'd0);
  assign ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign bs  = (div_by_zero || ovf) ? 32'd1 : b;
  assign bu  = div_by_zero ? 32'd1 : b;

  assign q_s = ovf ? a : 32'($signed(a) / $signed(bs));
  assign r_s = ovf ? 32'd0 : 32'($signed(a) % $signed(bs));
  assign q_u = a / bu;
  assign r_u = a % bu;

  always_comb begin
    hi_next = 32'd0;
    lo_next = 32'd0;
    unique case (1'b1)
      (op == MD_MULT):  {hi_next, lo_next} = prod_s;
      (op == MD_MULTU): {hi_next, lo_next} = prod_u;
      (op == MD_DIV):   {hi_next, lo_next} = {r_s, q_s};
      (op == MD_DIVU):  {hi_next, lo_next} = {r_u, q_u};
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning HI/LO.
// Fixed-latency FSM, hazard stall request and HI/LO read mux.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI_LO_rdata,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ?
                                 MUL_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] hi_next;
  logic [31:0] lo_next;
  logic        div_by_zero;

  md_arith u_arith (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .hi_next     (hi_next),
    .lo_next     (lo_next),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MD_NONE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && is_md_op(md_op)) begin
          state_d = ST_RUN;
          a_d     = rs_data;
          b_d     = rt_data;
          op_d    = md_op;
          cnt_d   = is_div_op(md_op) ? CW'(DIV_CYCLES)
                                     : CW'(MUL_CYCLES);
        end else if (md_use && md_op == MD_MTHI) begin
          hi_d = rs_data;
        end else if (md_use && md_op == MD_MTLO) begin
          lo_d = rs_data;
        end
      end
      ST_RUN: begin
        // start/mthi/mtlo cannot reach E while running
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!div_by_zero || !is_div_op(op_q)) begin
            hi_d = hi_next;
            lo_d = lo_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q == ST_RUN);
  assign stall_req   = md_use & (busy | start);
  assign HI_LO_rdata = (md_op == MD_MFHI) ? hi_q : lo_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule
